fir_sched: RTL and testbench

Stream-side sequencer for the `fir` block. It accepts samples on a valid/ready input stream and buffers them in a 2-entry FIFO. It issues each sample to the FIR as a single-cycle `ce` pulse, waits for the FIR's `valid`, then presents every DECIM-th result on a valid/ready output stream. It sits between the upstream sample source and a single `fir` instance and is the only driver of that instance's `ce` and `samp_i`.

---
 rtl/fir_sched.sv | 150 +++++++++++++++
 tb/tb_fir_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sched.sv
// Stream sequencer for a single fir instance: 2-entry input FIFO, one ce pulse per sample, decimated valid/ready output.
// Optional wait-timeout with sticky err is enabled by defining FIR_SCHED_TIMEOUT_EN.
module fir_sched #(
  parameter int DW      = 16,
  parameter int OW      = 37,
  parameter int DECIM   = 1,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [OW-1:0] out_full,
  output logic          fir_ce,
  output logic [DW-1:0] fir_samp,
  input  logic          fir_valid,
  input  logic [DW-1:0] fir_scaled,
  input  logic [OW-1:0] fir_full,
  output logic          busy,
  output logic          err
);

  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t        r_state, w_next;
  logic [DW-1:0] r_mem [2];
  logic          r_wptr, r_rptr;
  logic [1:0]    r_count;
  logic [CW-1:0] r_dec_cnt;
  logic          r_fir_ce;
  logic [DW-1:0] r_fir_samp;
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic [OW-1:0] r_out_full;
  logic          w_push, w_pop, w_result, w_keep, w_timeout;
  logic [DW-1:0] w_head;

  assign in_ready  = (r_count != 2'd2);
  assign w_push    = in_valid && in_ready;
  assign w_head    = r_mem[r_rptr];
  assign w_keep    = (r_dec_cnt == CW'(DECIM - 1));
  assign fir_ce    = r_fir_ce;
  assign fir_samp  = r_fir_samp;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_full  = r_out_full;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_count != 2'd0 && !r_out_valid) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (fir_valid || w_timeout) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_pop    = (r_state == S_ISSUE);
    busy     = (r_state != S_IDLE);
    w_result = (r_state == S_WAIT) && fir_valid;
  end

  // ce/samp are registered from the next state, so the pulse coincides exactly with ISSUE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fir_ce   <= 1'b0;
      r_fir_samp <= '0;
    end else begin
      r_fir_ce <= (w_next == S_ISSUE);
      if (r_state == S_IDLE && w_next == S_ISSUE) r_fir_samp <= w_head;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dec_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_full  <= '0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      if (w_result) begin
        if (w_keep) begin
          r_dec_cnt   <= '0;
          r_out_valid <= 1'b1;
          r_out_data  <= fir_scaled;
          r_out_full  <= fir_full;
        end else begin
          r_dec_cnt <= r_dec_cnt + 1'b1;
        end
      end
    end
  end

`ifdef FIR_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_wait_cnt;
  logic          r_err;

  assign w_timeout = (r_state == S_WAIT) && !fir_valid && (r_wait_cnt == TW'(TIMEOUT - 1));
  assign err       = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)     r_wait_cnt <= '0;
      else if (r_state == S_WAIT) r_wait_cnt <= r_wait_cnt + TW'(1);
      if (w_timeout) r_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_fir_sched.sv
// Bench for fir_sched: DECIM=1 and DECIM=3 instances, each with its own FIR model, random driver and cycle-level reference.
// Define FIR_SCHED_TIMEOUT_EN for both RTL and bench to exercise the timeout path.
module tb_fir_sched;
  localparam int DW  = 16;
  localparam int OW  = 37;
  localparam int TO  = 64;
  localparam int LAT = 26;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_target = 0;
  int unsigned pv = 0;
  int unsigned pr = 100;
  int unsigned dval = 0;
  bit          mute = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] fs(input logic [DW-1:0] x);
    return {x[DW-2:0], 1'b0} + x + 16'h1234;
  endfunction

  function automatic logic [OW-1:0] ff(input logic [DW-1:0] x);
    return {5'd0, x, ~x} ^ 37'h0A5A5A5A5A;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int D = (g == 0) ? 1 : 3;

    logic          iv, ir, ov, ordy, ce, fv, bsy, er;
    logic [DW-1:0] id, od, samp, fsc;
    logic [OW-1:0] ofu, ffu;

    fir_sched #(.DW(DW), .OW(OW), .DECIM(D), .TIMEOUT(TO)) u_dut (
      .clk(clk), .rst(rst),
      .in_valid(iv), .in_ready(ir), .in_data(id),
      .out_valid(ov), .out_ready(ordy), .out_data(od), .out_full(ofu),
      .fir_ce(ce), .fir_samp(samp),
      .fir_valid(fv), .fir_scaled(fsc), .fir_full(ffu),
      .busy(bsy), .err(er)
    );

    // FIR stand-in: result appears LAT cycles after the ce cycle; not cleared by rst
    int            fcnt = 0;
    logic [DW-1:0] flat = '0;
    initial begin fv = 1'b0; fsc = '0; ffu = '0; iv = 1'b0; id = '0; ordy = 1'b0; end
    always @(posedge clk) begin
      #1;
      fv  = 1'b0;
      fsc = DW'($urandom);
      ffu = OW'({$urandom, $urandom});
      if (fcnt > 0) begin
        fcnt--;
        if (fcnt == 0 && !mute) begin
          fv = 1'b1; fsc = fs(flat); ffu = ff(flat);
        end
      end
      if (ce) begin fcnt = LAT; flat = samp; end
      if (n_target > acc_cnt && $urandom_range(99) < pv) begin
        iv = 1'b1;
        id = (dval != 0) ? DW'(dval) : DW'($urandom);
      end else begin
        iv = 1'b0;
      end
      ordy = ($urandom_range(99) < pr);
    end

    // Reference: sample queue, one-in-flight rule, decimation count, output register
    logic [DW-1:0] q[$];
    logic [DW-1:0] cur = '0, exp_od = '0;
    logic [OW-1:0] exp_of = '0;
    bit inflight = 0, nxt_ce = 0, exp_ov = 0, exp_err = 0, quiet = 1;
    int wcnt = 0, nres = 0, acc_cnt = 0, out_cnt = 0, ce_cnt = 0;

    always @(negedge clk) begin
      bit e_ce, e_busy, ov_now;
      int sz;
      if (rst) begin
        q.delete();
        inflight = 0; nxt_ce = 0; exp_ov = 0; exp_err = 0; quiet = 1;
        wcnt = 0; nres = 0; acc_cnt = 0; out_cnt = 0; ce_cnt = 0;
      end else begin
        sz = q.size(); e_ce = nxt_ce; e_busy = e_ce || inflight; ov_now = exp_ov;
        check($sformatf("g%0d.in_ready", g), 64'(ir), 64'(sz < 2));
        check($sformatf("g%0d.fir_ce", g), 64'(ce), 64'(e_ce));
        check($sformatf("g%0d.busy", g), 64'(bsy), 64'(e_busy));
        check($sformatf("g%0d.out_valid", g), 64'(ov), 64'(exp_ov));
        check($sformatf("g%0d.err", g), 64'(er), 64'(exp_err));
        if (exp_ov) begin
          check($sformatf("g%0d.out_data", g), 64'(od), 64'(exp_od));
          check($sformatf("g%0d.out_full", g), 64'(ofu), 64'(exp_of));
          if (ordy) begin exp_ov = 0; out_cnt++; end
        end
        if (inflight) begin
          if (fv) begin
            inflight = 0; nres++;
            if (nres % D == 0) begin exp_ov = 1; exp_od = fs(cur); exp_of = ff(cur); end
          end
`ifdef FIR_SCHED_TIMEOUT_EN
          else begin
            wcnt++;
            if (wcnt == TO) begin inflight = 0; exp_err = 1; end
          end
`endif
        end
        if (e_ce && sz > 0) begin
          check($sformatf("g%0d.fir_samp", g), 64'(samp), 64'(q[0]));
          cur = q.pop_front();
          ce_cnt++; inflight = 1; wcnt = 0;
        end
        if (iv && sz < 2) begin q.push_back(id); acc_cnt++; end
        nxt_ce = !e_busy && sz > 0 && !ov_now;
        quiet  = (q.size() == 0) && !inflight && !exp_ov && !nxt_ce;
      end
    end

    task automatic chk_rst();
      check($sformatf("g%0d.rst in_ready", g), 64'(ir), 64'(1));
      check($sformatf("g%0d.rst out_valid", g), 64'(ov), 64'(0));
      check($sformatf("g%0d.rst out_data", g), 64'(od), 64'(0));
      check($sformatf("g%0d.rst out_full", g), 64'(ofu), 64'(0));
      check($sformatf("g%0d.rst fir_ce", g), 64'(ce), 64'(0));
      check($sformatf("g%0d.rst fir_samp", g), 64'(samp), 64'(0));
      check($sformatf("g%0d.rst busy", g), 64'(bsy), 64'(0));
      check($sformatf("g%0d.rst err", g), 64'(er), 64'(0));
    endtask
  end

  task automatic wait_quiet(input int budget);
    int c = 0;
    while (!(g_inst[0].quiet && g_inst[1].quiet &&
             g_inst[0].acc_cnt == n_target && g_inst[1].acc_cnt == n_target)) begin
      @(posedge clk); #2;
      c++;
      if (c >= budget) begin
        check("drain_budget", 64'(0), 64'(1));
        break;
      end
    end
  endtask

  task automatic run(input int n, input int unsigned v, input int unsigned r);
    n_target = n; pv = v; pr = r;
    wait_quiet(5000);
    pv = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2; rst = 1'b1;
    repeat (2) @(posedge clk);
    #2; rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #2;
    g_inst[0].chk_rst(); g_inst[1].chk_rst();
    rst = 1'b0;

    dval = 16'h0100;
    run(1, 100, 100);
    dval = 0;
    check("single_outs_d1", 64'(g_inst[0].out_cnt), 64'(1));
    check("single_outs_d3", 64'(g_inst[1].out_cnt), 64'(0));

    do_reset();
    run(5, 100, 100);
    check("burst_ce_d1", 64'(g_inst[0].ce_cnt), 64'(5));
    check("burst_ce_d3", 64'(g_inst[1].ce_cnt), 64'(5));

    do_reset();
    run(9, 100, 100);
    check("decim_outs_d1", 64'(g_inst[0].out_cnt), 64'(9));
    check("decim_outs_d3", 64'(g_inst[1].out_cnt), 64'(3));

    do_reset();
    n_target = 3; pv = 100; pr = 0;
    repeat (100) @(posedge clk);
    #2;
    check("hold_ce_d1", 64'(g_inst[0].ce_cnt), 64'(1));
    check("hold_ce_d3", 64'(g_inst[1].ce_cnt), 64'(3));
    check("hold_ov_d1", 64'(g_inst[0].ov), 64'(1));
    run(3, 100, 100);

    do_reset();
    run(40, 60, 50);

`ifdef FIR_SCHED_TIMEOUT_EN
    do_reset();
    mute = 1'b1;
    run(2, 100, 100);
    check("timeout_err_d1", 64'(g_inst[0].er), 64'(1));
    check("timeout_err_d3", 64'(g_inst[1].er), 64'(1));
    mute = 1'b0;
`endif

    // async reset in the middle of WAIT; the stale FIR result must be ignored afterwards
    n_target = g_inst[0].acc_cnt + 1; pv = 100; pr = 100;
    repeat (8) @(posedge clk);
    pv = 0;
    check("midwait_busy", 64'(g_inst[0].bsy), 64'(1));
    #3; rst = 1'b1;
    #1;
    g_inst[0].chk_rst(); g_inst[1].chk_rst();
    @(posedge clk); #2; rst = 1'b0;
    repeat (40) @(posedge clk);
    #2;
    check("stale_ignored", 64'(g_inst[0].ov), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
